// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types: the IF/ID payload, the fetch FSM states and the fetch buffer depth.
package pipeline_types;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } if_id_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_BUF_DEPTH = 2;

    // Sequential PC, 32-bit modulo so 32'hFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_skid_buffer.sv
// Two-entry if_id_t FIFO kept as a shift register so the head is always a plain register.
module fetch_skid_buffer
    import pipeline_types::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  if_id_t     push_data,
    output if_id_t     head,
    output logic       head_valid,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);

    logic   v0_r;
    logic   v1_r;
    if_id_t d0_r;
    if_id_t d1_r;

    // Entry storage: entry 0 is the head, entry 1 only ever valid when entry 0 is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
            d0_r <= '0;
            d1_r <= '0;
        end else if (flush) begin
            v0_r <= 1'b0;
            v1_r <= 1'b0;
        end else begin
            case ({push, pop && v0_r})
                2'b10: begin
                    if (!v0_r) begin
                        d0_r <= push_data;
                        v0_r <= 1'b1;
                    end else if (!v1_r) begin
                        d1_r <= push_data;
                        v1_r <= 1'b1;
                    end
                end
                2'b01: begin
                    d0_r <= d1_r;
                    v0_r <= v1_r;
                    v1_r <= 1'b0;
                end
                2'b11: begin
                    if (v1_r) begin
                        d0_r <= d1_r;
                        d1_r <= push_data;
                    end else begin
                        d0_r <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head       = d0_r;
    assign head_valid = v0_r;
    assign full       = v1_r;
    assign empty      = !v0_r;
    assign count      = {v1_r, v0_r & ~v1_r};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight, buffers words for decode.
// Optional FETCH_PERF_CNT_EN adds saturating delivered/stall counters on perf_*.
module fetch_stage
    import pipeline_types::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_id_valid,
    output if_id_t      if_id,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    generate
        if (BUF_DEPTH != FETCH_BUF_DEPTH) begin : g_bad_depth
            $error("fetch_stage: BUF_DEPTH must be 2");
        end
    endgenerate

    fetch_state_e state_r;
    logic [31:0]  pc_r;
    logic [31:0]  req_addr_r;
    logic [31:0]  req_pc_r;
    logic         req_valid_r;
    logic         outstanding_r;
    logic         epoch_r;
    logic         req_epoch_r;

    logic         push_s;
    logic         pop_s;
    logic         accept_s;
    logic         space_s;
    logic         buf_full_s;
    logic         buf_empty_s;
    logic [1:0]   buf_count_s;
    logic [2:0]   count_next_s;
    logic [31:0]  redirect_aligned_s;

    assign accept_s           = req_valid_r && imem_req_ready;
    assign pop_s              = !buf_empty_s && id_ready;
    // A response belongs to the current stream only if its tag matches the live epoch.
    assign push_s             = (state_r == WAIT) && imem_rsp_valid && (req_epoch_r == epoch_r)
                                && !redirect_valid && (!buf_full_s || pop_s);
    assign count_next_s       = {1'b0, buf_count_s} + {2'b00, push_s} - {2'b00, pop_s};
    assign space_s            = (count_next_s < 3'd2);
    assign redirect_aligned_s = redirect_pc & PC_ALIGN_MASK;

    fetch_skid_buffer u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .push_data  ({req_pc_r, pc_plus4(req_pc_r), imem_rsp_data}),
        .head       (if_id),
        .head_valid (if_id_valid),
        .full       (buf_full_s),
        .empty      (buf_empty_s),
        .count      (buf_count_s)
    );

    // Fetch FSM: PC, request handshake, outstanding tracking and epoch tagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= REQ;
            pc_r          <= RESET_PC;
            req_addr_r    <= RESET_PC;
            req_pc_r      <= 32'h0000_0000;
            req_valid_r   <= 1'b0;
            outstanding_r <= 1'b0;
            epoch_r       <= 1'b0;
            req_epoch_r   <= 1'b0;
        end else if (redirect_valid) begin
            pc_r <= redirect_aligned_s;
            // Tag the in-flight request with the old epoch so it can never match again.
            if (accept_s || outstanding_r) begin
                epoch_r     <= ~epoch_r;
                req_epoch_r <= epoch_r;
            end
            if (accept_s || (outstanding_r && !imem_rsp_valid)) begin
                outstanding_r <= 1'b1;
                req_valid_r   <= 1'b0;
                state_r       <= WAIT;
            end else begin
                outstanding_r <= 1'b0;
                req_valid_r   <= 1'b1;
                req_addr_r    <= redirect_aligned_s;
                state_r       <= REQ;
            end
        end else begin
            case (state_r)
                REQ: begin
                    if (req_valid_r) begin
                        if (imem_req_ready) begin
                            outstanding_r <= 1'b1;
                            req_pc_r      <= req_addr_r;
                            req_epoch_r   <= epoch_r;
                            pc_r          <= pc_plus4(pc_r);
                            req_valid_r   <= 1'b0;
                            state_r       <= WAIT;
                        end
                    end else if (space_s) begin
                        req_valid_r <= 1'b1;
                        req_addr_r  <= pc_r;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        outstanding_r <= 1'b0;
                        if (space_s) begin
                            req_valid_r <= 1'b1;
                            req_addr_r  <= pc_r;
                            state_r     <= REQ;
                        end else begin
                            state_r <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (space_s) begin
                        req_valid_r <= 1'b1;
                        req_addr_r  <= pc_r;
                        state_r     <= REQ;
                    end
                end
                default: begin
                    req_valid_r <= 1'b0;
                    state_r     <= REQ;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = req_addr_r;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Saturating delivered-instruction and decode-stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'h0;
            perf_stall_r   <= 32'h0;
        end else begin
            if (pop_s && (perf_fetched_r != 32'hFFFF_FFFF)) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (if_id_valid && !id_ready && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_r;
    assign perf_stall   = perf_stall_r;
`else
    assign perf_fetched = 32'h0;
    assign perf_stall   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reset table, hand-written corner sequences, random soak.
module tb_fetch_stage;
    import pipeline_types::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        if_id_valid;
    if_id_t      if_id;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_id_valid(if_id_valid), .if_id(if_id), .perf_fetched(perf_fetched), .perf_stall(perf_stall)
    );

    // Second instance starting near the top of the address space.
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = 32'h0;
    logic        w_valid;
    if_id_t      w_if_id;
    logic [31:0] w_perf_fetched;
    logic [31:0] w_perf_stall;
    logic        w_ready_one = 1'b1;
    logic        w_no_redirect = 1'b0;
    logic [31:0] w_redirect_pc = 32'h0;

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_ready_one), .imem_req_addr(w_req_addr),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .redirect_valid(w_no_redirect), .redirect_pc(w_redirect_pc), .id_ready(w_ready_one),
        .if_id_valid(w_valid), .if_id(w_if_id), .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Instruction memory model: in-order, one response per accepted request after mem_lat cycles.
    int unsigned mem_lat  = 1;
    bit          mem_rand = 1'b0;
    int unsigned cyc      = 0;
    logic [31:0] q_addr[$];
    int unsigned q_due[$];

    always @(posedge clk) begin
        cyc++;
        if (imem_rsp_valid) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + mem_lat - 1);
        end
    end

    always @(negedge clk) begin
        imem_req_ready = mem_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Single-cycle memory for the wrap instance.
    logic        w_acc = 1'b0;
    logic [31:0] w_acc_addr = 32'h0;
    always @(posedge clk) begin
        w_acc      = w_req_valid;
        w_acc_addr = w_req_addr;
    end
    always @(negedge clk) begin
        w_rsp_valid = w_acc;
        w_rsp_data  = instr_of(w_acc_addr);
    end

    logic [31:0] w_pcs[$];
    logic [31:0] w_pc4s[$];
    always @(negedge clk) begin
        #2;
        if (rst_n && w_valid && w_pcs.size() < 3) begin
            w_pcs.push_back(w_if_id.pc);
            w_pc4s.push_back(w_if_id.pc4);
        end
    end

    // Reference model: delivered PCs form a +4 stream restarted by every redirect or reset.
    logic [31:0] exp_pc = 32'h0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_pc = 32'h0;
        end else begin
            if (if_id_valid && id_ready) begin
                check32("sb_pc", if_id.pc, exp_pc);
                check32("sb_pc4", if_id.pc4, exp_pc + 32'd4);
                check32("sb_instr", if_id.instr, instr_of(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
        end
    end

    // Request must stay up with a stable address until accepted, unless redirected.
    logic        p_valid = 1'b0;
    logic        p_ready = 1'b0;
    logic        p_redir = 1'b0;
    logic        p_rst   = 1'b0;
    logic [31:0] p_addr  = 32'h0;
    always @(negedge clk) begin
        #3;
        if (rst_n && p_rst && p_valid && !p_ready && !p_redir) begin
            check32("req_hold_valid", {31'b0, imem_req_valid}, 32'h1);
            check32("req_hold_addr", imem_req_addr, p_addr);
        end
        p_valid = imem_req_valid;
        p_ready = imem_req_ready;
        p_redir = redirect_valid;
        p_rst   = rst_n;
        p_addr  = imem_req_addr;
    end

    typedef struct {
        logic        id_rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
    } vec_t;

    vec_t tbl[8];
    logic [31:0] wrap_exp[3];

    task automatic wait_valid_check_pc(input string name, input logic [31:0] pc_exp);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (if_id_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            check32(name, if_id.pc, pc_exp);
        end else begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for if_id_valid, required pc=%h", name, pc_exp);
        end
    endtask

    task automatic wait_accept(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid && imem_req_ready) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for request accept", name);
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 1'b1, 32'h0, 1'b1, 32'h4};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h8};
        tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h8, 1'b1, 32'hC};
        tbl[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check32("rst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check32("rst_req_addr", imem_req_addr, 32'h0);
        check32("rst_if_id_pc", if_id.pc, 32'h0);
        check32("rst_if_id_instr", if_id.instr, 32'h0);
        check32("rst_perf_fetched", perf_fetched, 32'h0);
        check32("rst_perf_stall", perf_stall, 32'h0);
        rst_n = 1'b1;

        // Cycle-exact start-up with 1-cycle memory and decode always ready.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            id_ready = tbl[i].id_rdy;
            check32($sformatf("tbl%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) begin
                check32($sformatf("tbl%0d_pc", i), if_id.pc, tbl[i].exp_pc);
                check32($sformatf("tbl%0d_pc4", i), if_id.pc4, tbl[i].exp_pc + 32'd4);
            end
            check32($sformatf("tbl%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, tbl[i].exp_req_valid});
            if (tbl[i].exp_req_valid) begin
                check32($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].exp_req_addr);
            end
        end

        // Decode stall: buffer fills, requests stop, FSM parks in HOLD.
        repeat (10) begin
            @(negedge clk); #1;
            id_ready = 1'b0;
        end
        check32("stall_if_id_valid", {31'b0, if_id_valid}, 32'h1);
        check32("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check32("stall_state", 32'(dut.state_r), 32'(HOLD));
        check32("stall_count", 32'(dut.u_buf.count), 32'd2);
        repeat (10) begin
            @(negedge clk); #1;
            id_ready = 1'b1;
        end

        // Redirect while a request is outstanding.
        mem_lat = 3;
        wait_accept("redir_out_accept");
        @(negedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        @(negedge clk); #1;
        redirect_valid = 1'b0;
        wait_valid_check_pc("redir_out_first_pc", 32'h0000_0100);

        // Redirect coincident with response, push and pop.
        mem_lat  = 1;
        id_ready = 1'b0;
        begin
            bit found = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk); #1;
                if (imem_rsp_valid && if_id_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            if (found) begin
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0202;
                id_ready       = 1'b1;
                @(negedge clk); #1;
                redirect_valid = 1'b0;
                check32("redir_coinc_flush_valid", {31'b0, if_id_valid}, 32'h0);
                check32("redir_coinc_flush_count", 32'(dut.u_buf.count), 32'd0);
                wait_valid_check_pc("redir_coinc_first_pc", 32'h0000_0200);
            end else begin
                checks++;
                failures++;
                $display("FAIL redir_coinc timeout waiting for rsp_valid with if_id_valid");
            end
        end

        // Reset in the middle of a transaction; the late response must be ignored.
        mem_lat  = 3;
        id_ready = 1'b1;
        wait_accept("midrst_accept");
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); #1;
        check32("midrst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
        check32("midrst_req_addr", imem_req_addr, 32'h0);
        rst_n = 1'b1;
        wait_valid_check_pc("midrst_first_pc", 32'h0);

        // Randomized soak against the reference model.
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            mem_lat        = $urandom_range(1, 3);
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF6 : $urandom();
        end
        @(negedge clk); #1;
        redirect_valid = 1'b0;

        // Performance counters: 3 stalled cycles then 5 deliveries from reset.
        mem_rand = 1'b0;
        mem_lat  = 1;
        id_ready = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
        begin
            int  pops  = 0;
            bit  found = 1'b0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk); #1;
                if (if_id_valid) begin
                    found = 1'b1;
                    break;
                end
            end
            repeat (2) @(negedge clk);
            @(negedge clk); #1;
            id_ready = 1'b1;
            for (int i = 0; i < 100; i++) begin
                if (if_id_valid) pops++;
                if (pops == 5) break;
                @(negedge clk); #1;
            end
            @(negedge clk); #1;
            id_ready = 1'b0;
            if (!found) begin
                checks++;
                failures++;
                $display("FAIL perf timeout waiting for first if_id_valid");
            end
`ifdef FETCH_PERF_CNT_EN
            check32("perf_fetched", perf_fetched, 32'd5);
            check32("perf_stall", perf_stall, 32'd3);
`else
            check32("perf_fetched_absent", perf_fetched, 32'd0);
            check32("perf_stall_absent", perf_stall, 32'd0);
`endif
        end

        // PC wrap from RESET_PC = FFFF_FFF8.
        check32("wrap_count", w_pcs.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < w_pcs.size()) begin
                check32($sformatf("wrap_pc%0d", i), w_pcs[i], wrap_exp[i]);
                check32($sformatf("wrap_pc4_%0d", i), w_pc4s[i], wrap_exp[i] + 32'd4);
            end
        end
        if (w_pc4s.size() > 1) begin
            check32("wrap_pc4_at_fffffffc", w_pc4s[1], 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
